// File: rtl/arm_mem_pkg.sv
// Shared types and address helpers for the MEM-stage data memory arbiter.
package arm_mem_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ACC_P  = 3'd1,
        DONE_P = 3'd2,
        ACC_D  = 3'd3,
        DONE_D = 3'd4
    } arb_state_e;

    localparam int unsigned BASE_ADDR_DEF = 1024;

    typedef struct packed {
        logic        valid;
        logic [31:0] word;
    } xlate_t;

    // The word index stays full width so the caller can both truncate and range-check it.
    function automatic xlate_t translate_addr(input logic [31:0] byteAddr,
                                              input logic [31:0] baseAddr,
                                              input int unsigned addrW);
        xlate_t      res;
        logic [31:0] offset;
        offset    = byteAddr - baseAddr;
        res.word  = {2'b00, offset[31:2]};
        res.valid = (byteAddr >= baseAddr) && ((res.word >> addrW) == 32'd0);
        return res;
    endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// Wait-state counter: cleared while idle, stepped once per access cycle, done at WAIT_STATES.
module mem_wait_counter #(
    parameter int unsigned WAIT_STATES = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic inc_i,
    output logic done_o
);

    localparam int unsigned CNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (inc_i) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done_o = (count_q == CNT_W'(WAIT_STATES));

endmodule

// File: rtl/data_mem_arbiter.sv
// Multi-cycle controller/arbiter for the single-port data memory shared by the MEM stage and debug port.
// Optional: define DBG_STARVE_GUARD_EN to let a long-waiting debug request pre-empt the pipeline.
module data_mem_arbiter
    import arm_mem_pkg::*;
#(
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned ADDR_W       = 6,
    parameter int unsigned WAIT_STATES  = 3,
    parameter int unsigned BASE_ADDR    = BASE_ADDR_DEF,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pipe_rd_en,
    input  logic              pipe_wr_en,
    input  logic [31:0]       pipe_addr,
    input  logic [DATA_W-1:0] pipe_wdata,
    output logic [DATA_W-1:0] pipe_rdata,
    output logic              pipe_ready,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              dbg_ack,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    arb_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              we_q, we_d;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] pipeRdata_q, pipeRdata_d;
    logic [DATA_W-1:0] dbgRdata_q, dbgRdata_d;

    xlate_t            pipeXlate;
    logic              pipeReq;
    logic              starveHit;
    logic              grantDbg;
    logic              cntClear;
    logic              cntInc;
    logic              cntDone;
    logic [DATA_W-1:0] capData;
    logic              unusedXlateHigh;

    assign pipeXlate       = translate_addr(pipe_addr, 32'(BASE_ADDR), ADDR_W);
    assign unusedXlateHigh = |(pipeXlate.word >> ADDR_W);
    assign pipeReq         = pipe_rd_en | pipe_wr_en;
    assign grantDbg        = dbg_req & (~pipeReq | starveHit);

`ifdef DBG_STARVE_GUARD_EN
    localparam int unsigned STARVE_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

    logic [STARVE_W-1:0] starveCnt_q, starveCnt_d;

    assign starveHit = (starveCnt_q >= STARVE_W'(STARVE_LIMIT));

    // Counts cycles a debug request waits while someone else owns or wins the memory.
    always_comb begin
        starveCnt_d = starveCnt_q;
        if ((state_q == IDLE) && grantDbg) begin
            starveCnt_d = '0;
        end else if (dbg_req && (state_q != ACC_D) && (state_q != DONE_D) && !starveHit) begin
            starveCnt_d = starveCnt_q + STARVE_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            starveCnt_q <= '0;
        end else begin
            starveCnt_q <= starveCnt_d;
        end
    end
`else
    localparam bit unusedStarveLimit = (STARVE_LIMIT != 0);
    assign starveHit = 1'b0;
`endif

    mem_wait_counter #(
        .WAIT_STATES(WAIT_STATES)
    ) uWaitCnt (
        .clk    (clk),
        .rst    (rst),
        .clear_i(cntClear),
        .inc_i  (cntInc),
        .done_o (cntDone)
    );

    // Suppressed (out-of-range) pipeline reads and all writes report zero.
    assign capData = (valid_q && !we_q) ? mem_rdata : '0;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        we_d        = we_q;
        valid_d     = valid_q;
        pipeRdata_d = pipeRdata_q;
        dbgRdata_d  = dbgRdata_q;
        cntClear    = 1'b0;
        cntInc      = 1'b0;
        mem_en      = 1'b0;
        mem_we      = 1'b0;
        dbg_ack     = 1'b0;
        unique case (state_q)
            IDLE: begin
                cntClear = 1'b1;
                if (grantDbg) begin
                    state_d = ACC_D;
                    addr_d  = dbg_addr;
                    wdata_d = dbg_wdata;
                    we_d    = dbg_we;
                    valid_d = 1'b1;
                end else if (pipeReq) begin
                    state_d = ACC_P;
                    addr_d  = pipeXlate.word[ADDR_W-1:0];
                    wdata_d = pipe_wdata;
                    we_d    = pipe_wr_en;
                    valid_d = pipeXlate.valid;
                end
            end
            ACC_P, ACC_D: begin
                mem_en = valid_q;
                mem_we = valid_q & we_q;
                cntInc = 1'b1;
                if (cntDone) begin
                    if (state_q == ACC_P) begin
                        state_d     = DONE_P;
                        pipeRdata_d = capData;
                    end else begin
                        state_d    = DONE_D;
                        dbgRdata_d = capData;
                    end
                end
            end
            DONE_P: begin
                state_d = IDLE;
            end
            DONE_D: begin
                dbg_ack = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            valid_q     <= 1'b0;
            pipeRdata_q <= '0;
            dbgRdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
            valid_q     <= valid_d;
            pipeRdata_q <= pipeRdata_d;
            dbgRdata_q  <= dbgRdata_d;
        end
    end

    assign pipe_ready = ~pipeReq | (state_q == DONE_P);
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign pipe_rdata = pipeRdata_q;
    assign dbg_rdata  = dbgRdata_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Randomised bench for data_mem_arbiter with a transaction-level memory/arbitration model.
// Honours DBG_STARVE_GUARD_EN when the design is built with it.
module tb_data_mem_arbiter;

    localparam int DATA_W       = 32;
    localparam int ADDR_W       = 6;
    localparam int WAIT_STATES  = 3;
    localparam int BASE_ADDR    = 1024;
    localparam int STARVE_LIMIT = 8;
    localparam int DEPTH        = 64;
    localparam int LAT          = WAIT_STATES + 2;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              pipe_rd_en, pipe_wr_en;
    logic [31:0]       pipe_addr;
    logic [DATA_W-1:0] pipe_wdata, pipe_rdata;
    logic              pipe_ready;
    logic              dbg_req, dbg_we;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_wdata, dbg_rdata;
    logic              dbg_ack;
    logic              mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    int nCompared   = 0;
    int nMismatched = 0;

    always #5 clk = ~clk;

    data_mem_arbiter #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .WAIT_STATES(WAIT_STATES),
        .BASE_ADDR(BASE_ADDR), .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk(clk), .rst(rst),
        .pipe_rd_en(pipe_rd_en), .pipe_wr_en(pipe_wr_en), .pipe_addr(pipe_addr),
        .pipe_wdata(pipe_wdata), .pipe_rdata(pipe_rdata), .pipe_ready(pipe_ready),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_rdata(dbg_rdata), .dbg_ack(dbg_ack),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // Synchronous single-port RAM standing in for the real data memory.
    logic [DATA_W-1:0] ramArr [DEPTH];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ramArr[mem_addr] <= mem_wdata;
            mem_rdata <= ramArr[mem_addr];
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void xlate(input logic [31:0] a, output bit ok, output int w);
        longint off;
        if (longint'(a) < longint'(BASE_ADDR)) begin
            ok = 0;
            w  = 0;
        end else begin
            off = (longint'(a) - longint'(BASE_ADDR)) / 4;
            ok  = (off < DEPTH);
            w   = int'(off % DEPTH);
        end
    endfunction

    // Model: memory contents plus who owns the port and how many cycles since the grant.
    logic [31:0] modelMem [DEPTH];
    bit          armed = 0;
    bit          busy, ownDbg, accOk, accWe, dbgKnown, addrZero;
    int          phase, accWord, starve;
    logic [31:0] accWdata, accRead, expPipeRdata, expDbgRdata;
    bit          pReq, eEn, eWe, eAck, eRdy, forceDbg;

    always @(negedge clk) begin
        if (armed) begin
            pReq = pipe_rd_en | pipe_wr_en;
            eEn  = 0;
            eWe  = 0;
            eAck = 0;
            eRdy = !pReq;
            if (busy) begin
                if (phase <= WAIT_STATES + 1) begin
                    eEn = accOk;
                    eWe = accOk && accWe;
                end else if (!ownDbg) begin
                    eRdy         = 1;
                    expPipeRdata = accRead;
                    if (accOk && accWe) modelMem[accWord] = accWdata;
                end else begin
                    eAck        = 1;
                    expDbgRdata = accRead;
                    dbgKnown    = !accWe;
                    if (accWe) modelMem[accWord] = accWdata;
                end
            end
            checkOutput("pipe_ready", 32'(pipe_ready), 32'(eRdy));
            checkOutput("dbg_ack", 32'(dbg_ack), 32'(eAck));
            checkOutput("mem_en", 32'(mem_en), 32'(eEn));
            checkOutput("mem_we", 32'(mem_we), 32'(eWe));
            checkOutput("pipe_rdata", pipe_rdata, expPipeRdata);
            if (dbgKnown) checkOutput("dbg_rdata", dbg_rdata, expDbgRdata);
            if (eEn) checkOutput("mem_addr", 32'(mem_addr), 32'(accWord));
            if (eWe) checkOutput("mem_wdata", mem_wdata, accWdata);
            if (addrZero) begin
                checkOutput("reset_mem_addr", 32'(mem_addr), 32'd0);
                checkOutput("reset_mem_wdata", mem_wdata, 32'd0);
            end

            if (!rst) begin
                busy         = 0;
                expPipeRdata = '0;
                expDbgRdata  = '0;
                dbgKnown     = 1;
                addrZero     = 1;
                starve       = 0;
            end else if (busy) begin
                if (dbg_req && !ownDbg && starve < STARVE_LIMIT) starve++;
                if (phase == LAT) busy = 0;
                else phase++;
            end else begin
                forceDbg = 0;
`ifdef DBG_STARVE_GUARD_EN
                forceDbg = dbg_req && (starve >= STARVE_LIMIT);
`endif
                if (dbg_req && (forceDbg || !pReq)) begin
                    busy     = 1;
                    ownDbg   = 1;
                    phase    = 1;
                    accOk    = 1;
                    accWe    = dbg_we;
                    accWord  = int'(dbg_addr);
                    accWdata = dbg_wdata;
                    accRead  = dbg_we ? 32'd0 : modelMem[accWord];
                    starve   = 0;
                    addrZero = 0;
                end else if (pReq) begin
                    xlate(pipe_addr, accOk, accWord);
                    busy     = 1;
                    ownDbg   = 0;
                    phase    = 1;
                    accWe    = pipe_wr_en;
                    accWdata = pipe_wdata;
                    accRead  = (accOk && !accWe) ? modelMem[accWord] : 32'd0;
                    addrZero = 0;
                    if (dbg_req && starve < STARVE_LIMIT) starve++;
                end
            end
        end
    end

    // One pipeline access: hold the request until pipe_ready, report cycles spent stalled.
    task automatic applyStimulus(input bit rd, input bit wr, input logic [31:0] a,
                                 input logic [31:0] wd, output int lat);
        int n;
        @(posedge clk); #1;
        pipe_rd_en = rd;
        pipe_wr_en = wr;
        pipe_addr  = a;
        pipe_wdata = wd;
        n = 0;
        @(negedge clk);
        while (!pipe_ready && n < 60) begin
            n++;
            @(negedge clk);
        end
        lat = n;
        if (n >= 60) begin
            nCompared++;
            nMismatched++;
            $display("[TB] FAIL pipe_timeout: still stalled after %0d cycles, expected ready by %0d", n, LAT);
        end
    endtask

    task automatic pipeIdle(input int k);
        @(posedge clk); #1;
        pipe_rd_en = 0;
        pipe_wr_en = 0;
        repeat (k - 1) @(posedge clk);
    endtask

    task automatic dbgRequest(input bit we, input logic [ADDR_W-1:0] a, input logic [31:0] wd,
                              input int limit, output logic [31:0] rdv, output bit acked);
        int n;
        @(posedge clk); #1;
        dbg_req   = 1;
        dbg_we    = we;
        dbg_addr  = a;
        dbg_wdata = wd;
        n = 0;
        @(negedge clk);
        while (!dbg_ack && n < limit) begin
            n++;
            @(negedge clk);
        end
        rdv   = dbg_rdata;
        acked = dbg_ack;
        if (!acked) begin
            nCompared++;
            nMismatched++;
            $display("[TB] FAIL dbg_timeout: no ack after %0d cycles, expected within %0d", n, limit);
        end
        @(posedge clk); #1;
        dbg_req = 0;
    endtask

    int          lat;
    logic [31:0] rdv;
    bit          acked, pipeDone, streamActive, ackDuring;
    int          kind, sel, gap;
    logic [31:0] ra;

    initial begin
        pipe_rd_en = 0; pipe_wr_en = 0; pipe_addr = '0; pipe_wdata = '0;
        dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
        mem_rdata = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ramArr[i]   = '0;
            modelMem[i] = '0;
        end
        busy = 0; ownDbg = 0; accOk = 0; accWe = 0; dbgKnown = 1; addrZero = 1;
        phase = 0; accWord = 0; starve = 0;
        accWdata = '0; accRead = '0; expPipeRdata = '0; expDbgRdata = '0;

        @(posedge clk); #1;
        armed = 1;
        @(negedge clk);
        checkOutput("reset_pipe_ready", 32'(pipe_ready), 32'd1);
        checkOutput("reset_mem_en", 32'(mem_en), 32'd0);
        checkOutput("reset_pipe_rdata", pipe_rdata, 32'd0);
        @(posedge clk); #1;
        rst = 1;

        $display("[TB] directed: store/load/out-of-range");
        applyStimulus(0, 1, 32'd1032, 32'hDEADBEEF, lat);
        checkOutput("store_latency", 32'(lat), 32'd5);
        checkOutput("store_mem_addr", 32'(mem_addr), 32'd2);
        applyStimulus(1, 0, 32'd1032, 32'h0, lat);
        checkOutput("load_latency", 32'(lat), 32'd5);
        checkOutput("load_data", pipe_rdata, 32'hDEADBEEF);
        applyStimulus(1, 0, 32'd1000, 32'h0, lat);
        checkOutput("oor_latency", 32'(lat), 32'd5);
        checkOutput("oor_data", pipe_rdata, 32'd0);
        applyStimulus(0, 1, 32'd1276, 32'h1234_5678, lat);
        applyStimulus(1, 0, 32'd1279, 32'h0, lat);
        checkOutput("top_word_data", pipe_rdata, 32'h1234_5678);
        applyStimulus(1, 0, 32'd1280, 32'h0, lat);
        checkOutput("past_top_data", pipe_rdata, 32'd0);
        applyStimulus(1, 1, 32'd1023, 32'hCAFE_F00D, lat);
        checkOutput("below_base_both_data", pipe_rdata, 32'd0);
        pipeIdle(2);

        $display("[TB] directed: simultaneous debug and pipeline");
        pipeDone = 0;
        fork
            begin
                applyStimulus(1, 0, 32'd1032, 32'h0, lat);
                pipeDone = 1;
                checkOutput("simul_pipe_data", pipe_rdata, 32'hDEADBEEF);
                pipeIdle(1);
            end
            begin
                dbgRequest(0, 6'd2, 32'h0, 100, rdv, acked);
                checkOutput("simul_pipe_first", 32'(pipeDone), 32'd1);
                checkOutput("simul_dbg_data", rdv, 32'hDEADBEEF);
            end
        join
        pipeIdle(2);

        $display("[TB] directed: reset during pipeline access");
        @(posedge clk); #1;
        pipe_rd_en = 1; pipe_wr_en = 0; pipe_addr = 32'd1032;
        @(posedge clk); #1;
        rst = 0; pipe_rd_en = 0;
        @(posedge clk); #1;
        rst = 1;
        @(negedge clk);
        checkOutput("abort_mem_en", 32'(mem_en), 32'd0);
        checkOutput("abort_pipe_ready", 32'(pipe_ready), 32'd1);
        checkOutput("abort_pipe_rdata", pipe_rdata, 32'd0);
        checkOutput("abort_dbg_ack", 32'(dbg_ack), 32'd0);
        pipeIdle(2);

        $display("[TB] directed: debug starvation under back-to-back loads");
        streamActive = 1;
        ackDuring    = 0;
        fork
            begin
                for (int i = 0; i < 20; i++) applyStimulus(1, 0, 32'd1024 + 32'(4 * i), 32'h0, lat);
                streamActive = 0;
                pipeIdle(1);
            end
            begin
                dbgRequest(0, 6'd2, 32'h0, 300, rdv, acked);
                ackDuring = streamActive;
            end
        join
`ifdef DBG_STARVE_GUARD_EN
        checkOutput("starve_ack_during_stream", 32'(ackDuring), 32'd1);
`else
        checkOutput("starve_ack_during_stream", 32'(ackDuring), 32'd0);
`endif
        pipeIdle(2);

        $display("[TB] random traffic");
        fork
            begin
                for (int i = 0; i < 120; i++) begin
                    kind = int'($urandom_range(0, 2));
                    sel  = int'($urandom_range(0, 9));
                    case (sel)
                        0:       ra = 32'(BASE_ADDR) - 32'($urandom_range(1, 40));
                        1:       ra = 32'(BASE_ADDR + 4 * DEPTH) + 32'($urandom_range(0, 40));
                        default: ra = 32'(BASE_ADDR) + 32'($urandom_range(0, 4 * DEPTH - 1));
                    endcase
                    applyStimulus(kind != 1, kind != 0, ra, $urandom, lat);
                    gap = int'($urandom_range(0, 3));
                    if (gap > 0) pipeIdle(gap);
                end
                pipeIdle(1);
            end
            begin
                logic [31:0] drv;
                bit          dack;
                for (int j = 0; j < 30; j++) begin
                    repeat ($urandom_range(0, 5)) @(posedge clk);
                    dbgRequest(1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, DEPTH - 1)),
                               $urandom, 400, drv, dack);
                end
            end
        join

        repeat (4) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
